wb_conv_initiator: RTL and testbench

WB_CONV_INITIATOR -- requirements
Module: wb_conv_initiator

---
 rtl/wb_conv_initiator_if.sv | 20 ++
 rtl/wb_conv_initiator.sv | 157 +++++++++++++++
 tb/tb_wb_conv_initiator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_conv_initiator_if.sv
// Wishbone-style bus between the conv-engine initiator and its target.
interface wb_conv_initiator_if;
  logic        wb_cyc;
  logic        wb_str;
  logic        wb_we;
  logic [7:0]  wb_addr;
  logic [31:0] wb_dout;
  logic [31:0] wb_din;
  logic        wb_ack;

  modport master (
    output wb_cyc, wb_str, wb_we, wb_addr, wb_dout,
    input  wb_din, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_str, wb_we, wb_addr, wb_dout,
    output wb_din, wb_ack
  );
endinterface

// File: rtl/wb_conv_initiator.sv
// Sequences weight/data writes and a result read to a conv engine over a Wishbone-style bus.
// Optional macro WB_INIT_ID_CHECK_EN adds an engine ID read (8'h81) before the first write.
module wb_conv_initiator #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [71:0] wgt,
  input  logic [63:0] pix,
  input  logic [2:0]  row,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] res_a,
  output logic [15:0] res_b,
  wb_conv_initiator_if.master wb
);

  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    IDLE,
`ifdef WB_INIT_ID_CHECK_EN
    ID_RD,
`endif
    W0, W1, W2, D0, D1, RD0, RD1, DONE, ERR
  } state_t;

  state_t         state, state_nx;
  logic [71:0]    wgt_q;
  logic [63:0]    pix_q;
  logic [2:0]     row_q;
  logic [CW-1:0]  cnt;
  logic           err_q;
  logic [31:0]    res_q;
  logic           accept;
  logic           wr_state;
  logic           timeout;

`ifdef WB_INIT_ID_CHECK_EN
  localparam logic [31:0] ENGINE_ID = 32'h414D5331;
  logic phase;
`endif

  assign accept   = (state == IDLE) && start;
  assign wr_state = (state == W0) || (state == W1) || (state == W2) ||
                    (state == D0) || (state == D1);
  assign timeout  = (cnt == CW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
`ifdef WB_INIT_ID_CHECK_EN
        state_nx = ID_RD;
`else
        state_nx = W0;
`endif
      end
`ifdef WB_INIT_ID_CHECK_EN
      ID_RD: if (phase) state_nx = (wb.wb_din == ENGINE_ID) ? W0 : ERR;
`endif
      W0:   if (wb.wb_ack) state_nx = W1;   else if (timeout) state_nx = ERR;
      W1:   if (wb.wb_ack) state_nx = W2;   else if (timeout) state_nx = ERR;
      W2:   if (wb.wb_ack) state_nx = D0;   else if (timeout) state_nx = ERR;
      D0:   if (wb.wb_ack) state_nx = D1;   else if (timeout) state_nx = ERR;
      D1:   if (wb.wb_ack) state_nx = RD0;  else if (timeout) state_nx = ERR;
      RD0:  state_nx = RD1;
      RD1:  state_nx = DONE;
      DONE: state_nx = IDLE;
      ERR:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wgt_q <= '0;
      pix_q <= '0;
      row_q <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      res_q <= '0;
`ifdef WB_INIT_ID_CHECK_EN
      phase <= 1'b0;
`endif
    end else begin
      if (accept) begin
        wgt_q <= wgt;
        pix_q <= pix;
        row_q <= row;
      end
      // Wait counter restarts on every acked write and outside write states.
      if (wr_state && !wb.wb_ack) cnt <= cnt + 1'b1;
      else                        cnt <= '0;
      if (accept)                 err_q <= 1'b0;
      else if (state_nx == ERR)   err_q <= 1'b1;
      if (state == RD1) res_q <= wb.wb_din;
`ifdef WB_INIT_ID_CHECK_EN
      phase <= (state == ID_RD) ? ~phase : 1'b0;
`endif
    end
  end

  always_comb begin
    wb.wb_cyc  = 1'b0;
    wb.wb_str  = 1'b0;
    wb.wb_we   = 1'b0;
    wb.wb_addr = '0;
    wb.wb_dout = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
`ifdef WB_INIT_ID_CHECK_EN
      ID_RD: begin
        busy = 1'b1; wb.wb_cyc = 1'b1; wb.wb_str = 1'b1; wb.wb_addr = 8'h81;
      end
`endif
      W0: begin
        busy = 1'b1; wb.wb_cyc = 1'b1; wb.wb_str = 1'b1; wb.wb_we = 1'b1;
        wb.wb_addr = 8'hD1; wb.wb_dout = wgt_q[31:0];
      end
      W1: begin
        busy = 1'b1; wb.wb_cyc = 1'b1; wb.wb_str = 1'b1; wb.wb_we = 1'b1;
        wb.wb_addr = 8'hD2; wb.wb_dout = wgt_q[63:32];
      end
      W2: begin
        busy = 1'b1; wb.wb_cyc = 1'b1; wb.wb_str = 1'b1; wb.wb_we = 1'b1;
        wb.wb_addr = 8'hD3; wb.wb_dout = {wgt_q[71:64], 24'h0};
      end
      D0: begin
        busy = 1'b1; wb.wb_cyc = 1'b1; wb.wb_str = 1'b1; wb.wb_we = 1'b1;
        wb.wb_addr = {5'b11000, row_q}; wb.wb_dout = pix_q[31:0];
      end
      D1: begin
        busy = 1'b1; wb.wb_cyc = 1'b1; wb.wb_str = 1'b1; wb.wb_we = 1'b1;
        wb.wb_addr = {5'b11001, row_q}; wb.wb_dout = pix_q[63:32];
      end
      RD0, RD1: begin
        busy = 1'b1; wb.wb_cyc = 1'b1; wb.wb_str = 1'b1; wb.wb_addr = 8'hA0;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign err   = err_q;
  assign res_a = res_q[15:0];
  assign res_b = res_q[31:16];

endmodule

// File: tb/tb_wb_conv_initiator.sv
// Self-checking bench for wb_conv_initiator: fixed vector table, corner sequences, random transactions.
module tb_wb_conv_initiator;

`ifdef WB_INIT_ID_CHECK_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 9;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [71:0] wgt = '0;
  logic [63:0] pix = '0;
  logic [2:0]  row = '0;
  logic        busy, done, err;
  logic [15:0] res_a, res_b;

  logic [7:0]  stall_addr = 8'h00;
  logic [31:0] rd_data = '0;
  logic [31:0] id_val = 32'h414D5331;
  int          rd_cnt;
  logic [39:0] obs[$];

  int tests = 0;
  int fails = 0;

  wb_conv_initiator_if bus();

  wb_conv_initiator #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .wgt(wgt), .pix(pix), .row(row),
    .busy(busy), .done(done), .err(err), .res_a(res_a), .res_b(res_b),
    .wb(bus)
  );

  always #5 clk = ~clk;

  // Target model: immediate ack except at stall_addr; read data only valid on second read cycle.
  assign bus.wb_ack = bus.wb_cyc & bus.wb_str & bus.wb_we & (bus.wb_addr != stall_addr);
  assign bus.wb_din = (rd_cnt == 1) ? ((bus.wb_addr == 8'h81) ? id_val : rd_data) : 32'hDEADBEEF;

  always @(posedge clk or negedge rst) begin
    if (!rst) rd_cnt <= 0;
    else      rd_cnt <= (bus.wb_cyc && !bus.wb_we) ? rd_cnt + 1 : 0;
  end

  always @(posedge clk) begin
    if (rst && bus.wb_cyc && bus.wb_str && bus.wb_we && bus.wb_ack)
      obs.push_back({bus.wb_addr, bus.wb_dout});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_txn(input logic [71:0] w, input logic [63:0] p, input logic [2:0] r,
                           input logic [31:0] rd, input int glitch_at);
    logic [39:0] exp[$];
    int   lat, ndone;
    logic err_first, busy_after;
    bit   seen;
    exp.push_back({8'hD1, w[31:0]});
    exp.push_back({8'hD2, w[63:32]});
    exp.push_back({8'hD3, w[71:64], 24'h000000});
    exp.push_back({8'(8'hC0 + r), p[31:0]});
    exp.push_back({8'(8'hC8 + r), p[63:32]});
    obs.delete();
    rd_data = rd;
    @(negedge clk);
    wgt = w; pix = p; row = r; start = 1'b1;
    lat = 1; seen = 0; ndone = 0; err_first = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0; wgt = w; pix = p; row = r;
      lat++;
      if (c == 0) err_first = err;
      if (done) begin
        seen = 1; ndone++;
      end else if (c == glitch_at) begin
        start = 1'b1; wgt = ~w; pix = ~p; row = ~r;
      end
    end
    @(negedge clk);
    busy_after = busy;
    if (done) ndone++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("latency", seen ? lat : 0, LAT);
    chk("done_count", ndone, 1);
    chk("busy_after_done", busy_after, 0);
    chk("err_cleared_on_start", err_first, 0);
    chk("err_at_end", err, 0);
    chk("n_writes", obs.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < obs.size()) chk($sformatf("write%0d", i), obs[i], exp[i]);
  endtask

  typedef struct {
    logic [71:0] w;
    logic [63:0] p;
    logic [2:0]  r;
    logic [31:0] rd;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [31:0] e_first;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [39:0] ref28[5];
    logic [71:0] rw;
    logic [63:0] rp;
    logic [31:0] rrd;
    int          cyc_cnt;

    vecs[0] = '{72'h09_08070605_04030201, 64'h11223344_55667788, 3'd3, 32'h00050007,
                16'h0007, 16'h0005, 32'h04030201};
    vecs[1] = '{72'hFF_FFFFFFFF_FFFFFFFF, 64'h0, 3'd7, 32'hFFFF0000,
                16'h0000, 16'hFFFF, 32'hFFFFFFFF};
    vecs[2] = '{72'h0, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 32'h12345678,
                16'h5678, 16'h1234, 32'h00000000};
    ref28 = '{40'hD1_04030201, 40'hD2_08070605, 40'hD3_09000000,
              40'hC3_55667788, 40'hCB_11223344};

    // Reset state
    #12;
    chk("reset_ctrl", {busy, done, err, bus.wb_cyc, bus.wb_str, bus.wb_we, bus.wb_addr}, 0);
    chk("reset_res", {res_a, res_b}, 0);
    chk("reset_dout", bus.wb_dout, 0);
    @(negedge clk);
    rst = 1'b1;

    // Literal write sequence and result for the reference vector
    check_txn(vecs[0].w, vecs[0].p, vecs[0].r, vecs[0].rd, -1);
    for (int i = 0; i < 5; i++)
      if (i < obs.size()) chk($sformatf("ref_write%0d", i), obs[i], ref28[i]);
    chk("ref_res", {res_b, res_a}, 32'h00050007);

    // Table vectors
    for (int v = 0; v < 3; v++) begin
      check_txn(vecs[v].w, vecs[v].p, vecs[v].r, vecs[v].rd, -1);
      chk($sformatf("vec%0d_res_a", v), res_a, vecs[v].ea);
      chk($sformatf("vec%0d_res_b", v), res_b, vecs[v].eb);
      if (obs.size() > 0) chk($sformatf("vec%0d_first", v), obs[0][31:0], vecs[v].e_first);
    end

    // Ack withheld on W1 -> timeout error
    stall_addr = 8'hD2;
    obs.delete();
    @(negedge clk);
    wgt = vecs[0].w; pix = vecs[0].p; row = vecs[0].r; start = 1'b1;
    cyc_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (err) break;
      if (bus.wb_cyc && bus.wb_addr == 8'hD2) cyc_cnt++;
    end
    chk("timeout_w1_cycles", cyc_cnt, 15);
    chk("timeout_err", err, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_bus_idle", {bus.wb_cyc, bus.wb_str, bus.wb_we, bus.wb_addr, bus.wb_dout}, 0);
    chk("timeout_writes", obs.size(), 1);
    @(negedge clk);
    @(negedge clk);
    chk("err_sticky", err, 1);
    stall_addr = 8'h00;
    check_txn(vecs[1].w, vecs[1].p, vecs[1].r, 32'hA5A5_5A5A, -1);
    chk("after_err_res", {res_b, res_a}, 32'hA5A55A5A);

    // Reset asserted during D0
    @(negedge clk);
    wgt = vecs[2].w; pix = vecs[2].p; row = 3'd5; start = 1'b1;
    cyc_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.wb_we && bus.wb_addr[7:3] == 5'b11000) break;
      cyc_cnt++;
    end
    chk("reached_d0", (cyc_cnt < 20), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ctrl", {busy, done, err, bus.wb_cyc, bus.wb_str, bus.wb_we, bus.wb_addr}, 0);
    chk("midrst_res", {res_a, res_b}, 0);
    chk("midrst_dout", bus.wb_dout, 0);
    @(negedge clk);
    rst = 1'b1;
    check_txn(vecs[0].w, vecs[0].p, vecs[0].r, 32'h0BAD_F00D, -1);
    chk("after_rst_res", {res_b, res_a}, 32'h0BADF00D);

    // Start pulsed while busy
    check_txn(vecs[0].w, vecs[0].p, 3'd6, 32'h1357_2468, 3);
    chk("glitch_res", {res_b, res_a}, 32'h13572468);

`ifdef WB_INIT_ID_CHECK_EN
    // Wrong engine ID -> error, no writes
    id_val = 32'h414D5330;
    obs.delete();
    @(negedge clk);
    wgt = vecs[0].w; pix = vecs[0].p; row = vecs[0].r; start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (err) break;
    end
    chk("id_bad_err", err, 1);
    @(negedge clk);
    chk("id_bad_writes", obs.size(), 0);
    id_val = 32'h414D5331;
    check_txn(vecs[0].w, vecs[0].p, vecs[0].r, 32'h00050007, -1);
    chk("id_good_res", {res_b, res_a}, 32'h00050007);
`endif

    // Random transactions against the behavioural model
    for (int i = 0; i < 8; i++) begin
      rw  = {8'($urandom), 32'($urandom), 32'($urandom)};
      rp  = {32'($urandom), 32'($urandom)};
      rrd = 32'($urandom);
      check_txn(rw, rp, 3'($urandom_range(7, 0)), rrd, (i % 2 == 1) ? 2 + i / 2 : -1);
      chk($sformatf("rand%0d_res_a", i), res_a, 16'(rrd % 65536));
      chk($sformatf("rand%0d_res_b", i), res_b, 16'(rrd / 65536));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
